// File: rtl/inst_sram_axi_rd_bridge_pkg.sv
// Shared AXI encodings and sizing helpers for the instruction-fetch read bridge.
package inst_sram_axi_rd_bridge_pkg;

    localparam int unsigned ARID_W = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_SIZE_BYTE  = 2'd0;
    localparam logic [1:0] AXI_SIZE_HALF  = 2'd1;
    localparam logic [1:0] AXI_SIZE_WORD  = 2'd2;

    // Width needed to count 0..max_out inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/inst_sram_axi_rd_bridge.sv
// SRAM-like instruction port (req/addr_ok/data_ok) to single-ID AXI3 read master.
module inst_sram_axi_rd_bridge
    import inst_sram_axi_rd_bridge_pkg::*;
#(
    parameter int unsigned        MAX_OUTSTANDING = 2,
    parameter logic [ARID_W-1:0]  ARID            = 4'd0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_sram_req,
    input  logic              inst_sram_wr,
    input  logic [1:0]        inst_sram_size,
    input  logic [3:0]        inst_sram_wstrb,
    input  logic [31:0]       inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic              inst_sram_addr_ok,
    output logic              inst_sram_data_ok,
    output logic [31:0]       inst_sram_rdata,
    output logic [ARID_W-1:0] arid,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [ARID_W-1:0] rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              err_sticky
);

    localparam int unsigned          CntW   = cnt_width(MAX_OUTSTANDING);
    localparam logic [CntW-1:0]      MaxCnt = CntW'(MAX_OUTSTANDING);
    localparam logic [CntW-1:0]      CntOne = CntW'(1);

    logic            arvalid_q, arvalid_d;
    logic [31:0]     araddr_q, araddr_d;
    logic [1:0]      size_q, size_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic            data_ok_q, data_ok_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic can_accept, addr_ok, ar_hs, r_consume, id_ok;
    logic unused_write_path;

    assign unused_write_path = ^{inst_sram_wstrb, inst_sram_wdata};

    assign can_accept = ~arvalid_q & (out_cnt_q < MaxCnt);
    assign addr_ok    = inst_sram_req & can_accept;
    assign ar_hs      = arvalid_q & arready;
    assign id_ok      = (rid == ARID);
    assign r_consume  = rvalid & rready & id_ok & (out_cnt_q != '0);

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        size_d    = size_q;
        out_cnt_d = out_cnt_q;
        data_ok_d = r_consume;
        rdata_d   = rdata_q;
        err_d     = err_q;

        if (addr_ok) begin
            arvalid_d = 1'b1;
            araddr_d  = inst_sram_addr;
            size_d    = inst_sram_size;
        end else if (ar_hs) begin
            arvalid_d = 1'b0;
        end

        unique case ({addr_ok, r_consume})
            2'b10:   out_cnt_d = out_cnt_q + CntOne;
            2'b01:   out_cnt_d = out_cnt_q - CntOne;
            default: out_cnt_d = out_cnt_q;
        endcase

        if (r_consume) begin
            rdata_d = rdata;
        end

        // Stray or malformed traffic is still acknowledged; it just latches the flag.
        if ((rvalid & rready & ~id_ok) ||
            (rvalid & (out_cnt_q == '0)) ||
            (r_consume & (rresp != 2'b00)) ||
            (r_consume & ~rlast) ||
            (addr_ok & inst_sram_wr)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            arvalid_q <= 1'b0;
            araddr_q  <= 32'd0;
            size_q    <= 2'd0;
            out_cnt_q <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            size_q    <= size_d;
            out_cnt_q <= out_cnt_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign inst_sram_addr_ok = addr_ok;
    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;

    assign arid    = ARID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q;
    assign rready  = resetn;

    assign err_sticky = err_q;

endmodule

// File: doc/inst_sram_axi_rd_bridge.md
Name: inst_sram_axi_rd_bridge

Overview:
Responder for the IF stage's SRAM-like instruction interface (req/addr_ok/data_ok), converting it to an AXI3 read-address/read-data master.
- Sits between the CPU instruction port and the AXI interconnect.
- Supports up to MAX_OUTSTANDING in-order reads, covering the pre-IF plus IF double-request pattern.
- Responses are registered so that data_ok/rdata are glitch-free one-cycle pulses.

Parameters:
MAX_OUTSTANDING, 2, maximum accepted-but-not-returned requests (1..4)
ARID, 4'd0, constant AXI ID driven on arid; also the only rid accepted

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
inst_sram_req  in  1  request valid from IF
inst_sram_wr  in  1  write flag; must be 0 for this port
inst_sram_size  in  2  transfer size code (0=byte, 1=half, 2=word)
inst_sram_wstrb  in  4  unused (write path absent)
inst_sram_addr  in  32  fetch address
inst_sram_wdata  in  32  unused
inst_sram_addr_ok  out  1  request accepted this cycle
inst_sram_data_ok  out  1  one-cycle pulse, read data valid
inst_sram_rdata  out  32  returned instruction word
arid  out  4  = ARID
araddr  out  32  latched request address
arlen  out  8  constant 0 (single beat)
arsize  out  3  {1'b0, latched size}
arburst  out  2  constant 2'b01 (INCR)
arlock/arcache/arprot  out  2/4/3  constant 0
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  R ID
rdata  in  32  R data
rresp  in  2  R response
rlast  in  1  R last (expected 1)
rvalid  in  1  R valid
rready  out  1  R ready
err_sticky  out  1  sticky protocol/response error flag

Behaviour:
- Reset (resetn=0 at posedge): arvalid=0, araddr=0, arsize=0, data_ok=0, rdata=0, out_cnt=0, err_sticky=0. rready=0 while resetn=0, and 1 afterwards.
- Reset mid-operation discards all outstanding state. Stale R beats arriving after reset count as unexpected (see rid/count rules).
- Accept condition (combinational): can_accept = ~arvalid & (out_cnt < MAX_OUTSTANDING).
  - addr_ok = req & can_accept, in the same cycle as req.
  - On addr_ok: latch addr and size, set arvalid=1 next cycle.
- arvalid holds, with araddr/arsize stable, until the arvalid&arready handshake, then clears the following cycle.
  - Minimum req->AR issue latency is 1 cycle.
  - Back-to-back acceptance is possible the cycle after the AR handshake.
- out_cnt, width $clog2(MAX_OUTSTANDING+1):
  - +1 on addr_ok.
  - -1 on a consumed R beat.
  - Both in the same cycle leaves it unchanged.
  - Never wraps: addr_ok is blocked at MAX, and consumption is ignored at 0.
- R beat consumed when rvalid & rready & (rid==ARID) & (out_cnt!=0). The next cycle: data_ok=1 and rdata=R data, for exactly one cycle (1-cycle response latency).
- Back-to-back R beats give back-to-back data_ok pulses; IF always accepts them, so there is no backpressure on data_ok.
- Responses return in request order (single ID), so no reordering buffer is needed.
- err_sticky is set, and never cleared except by reset, on any of:
  - rvalid with rid!=ARID (beat is still acknowledged but dropped, with no data_ok);
  - rvalid with out_cnt==0 (dropped);
  - consumed beat with rresp!=0 (data is still returned);
  - rlast=0 on a consumed beat;
  - addr_ok-eligible req with wr=1 (request is still treated as a read).
- Simultaneous AR handshake and R consumption in one cycle are both honoured.

Decomposition:
- Shared package: AXI constant encodings (AXI_BURST_INCR, AXI_SIZE_*), ARID width, and a function for outstanding-counter width.
- No sub-module is natural; a single module suffices. The counter and error logic stay inline.

Test Plan:
1. Single fetch: req addr=0x1c000000, size=2 -> addr_ok same cycle; arvalid next cycle with araddr=0x1c000000, arsize=3'd2, arlen=0; rvalid with rdata=0x02800000 -> data_ok 1 cycle later with rdata=0x02800000, out_cnt back to 0.
2. Two outstanding: req 0x1c000000 then 0x1c000004 (arready=1) and R delayed 5 cycles -> both addr_ok, third req held (addr_ok=0) while out_cnt=2; R beats 0xAAAA/0xBBBB -> data_ok pulses in order.
3. AR stall: arready=0 for 4 cycles -> arvalid/araddr stable, a further req gets no addr_ok until the handshake plus 1 cycle.
4. Same-cycle events: addr_ok coincides with R consumption at out_cnt=1 -> out_cnt stays 1 and data_ok pulses.
5. Errors: rvalid with rid=4'd3 -> no data_ok, err_sticky=1; separately rresp=2'b10 -> data_ok with data and err_sticky=1; rvalid with out_cnt=0 -> dropped, err_sticky=1.
6. Reset mid-flight: resetn low for 1 cycle with 2 outstanding -> all outputs at reset values, out_cnt=0; a late R beat afterwards sets err_sticky and produces no data_ok.
